// File: rtl/fsm_seq16_dwell_ctrl.sv
// Sixteen-step sequencer: each step is held for (dwell[step] + 1) cycles.
// Supports start/stop/abort control, pause/resume, and single-pass or looping modes.
module fsm_seq16_dwell_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_we,
    input  logic [3:0]  cfg_addr,
    input  logic [7:0]  cfg_data,
    input  logic        start,
    input  logic        stop,
    input  logic        abort,
    input  logic        oneshot,
    output logic        busy,
    output logic        paused,
    output logic [3:0]  cur_step,
    output logic [15:0] step_oh,
    output logic        adv,
    output logic        wrap,
    output logic        done
);

    localparam int unsigned STEP_W  = 4;
    localparam int unsigned DWELL_W = 8;
    localparam int unsigned N_STEPS = 16;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N_STEPS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [STEP_W-1:0]   step_nxt;
    logic [STEP_W-1:0]   step_inc;
    logic [DWELL_W-1:0]  cnt;
    logic [DWELL_W-1:0]  cnt_nxt;
    logic                mode;
    logic                mode_nxt;
    logic                adv_nxt;
    logic                wrap_nxt;
    logic                done_nxt;
    logic [DWELL_W-1:0]  dwell [N_STEPS];

    assign step_inc = STEP_W'(cur_step + 1'b1);

    // Dwell table. A write only changes the value used by later counter loads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(N_STEPS); i++) begin
                dwell[i] <= '0;
            end
        end else if (cfg_we) begin
            dwell[cfg_addr] <= cfg_data;
        end
    end

    // Next-state logic. Command priority is abort > stop > start.
    always_comb begin
        state_nxt = state;
        step_nxt  = cur_step;
        cnt_nxt   = cnt;
        mode_nxt  = mode;
        adv_nxt   = 1'b0;
        wrap_nxt  = 1'b0;
        done_nxt  = 1'b0;
        if (abort) begin
            state_nxt = IDLE;
            step_nxt  = '0;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        state_nxt = RUN;
                        step_nxt  = '0;
                        cnt_nxt   = dwell[0];
                        mode_nxt  = oneshot;
                        adv_nxt   = 1'b1;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_nxt = PAUSE;
                    end else if (cnt != '0) begin
                        cnt_nxt = cnt - 1'b1;
                    end else if (cur_step == LAST_STEP && mode) begin
                        // A single pass finishes here: go idle with no advance pulse.
                        state_nxt = IDLE;
                        step_nxt  = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        step_nxt = step_inc;
                        cnt_nxt  = dwell[step_inc];
                        adv_nxt  = 1'b1;
                        wrap_nxt = (cur_step == LAST_STEP);
                    end
                end
                PAUSE: begin
                    if (start && !stop) begin
                        state_nxt = RUN;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    step_nxt  = '0;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // State register together with the registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cur_step <= '0;
            cnt      <= '0;
            mode     <= 1'b0;
            busy     <= 1'b0;
            paused   <= 1'b0;
            step_oh  <= '0;
            adv      <= 1'b0;
            wrap     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cur_step <= step_nxt;
            cnt      <= cnt_nxt;
            mode     <= mode_nxt;
            busy     <= (state_nxt != IDLE);
            paused   <= (state_nxt == PAUSE);
            step_oh  <= (state_nxt != IDLE) ? (N_STEPS'(1) << step_nxt) : '0;
            adv      <= adv_nxt;
            wrap     <= wrap_nxt;
            done     <= done_nxt;
        end
    end

endmodule
